// File: rtl/store_queue_if.sv
// Store queue port bundle: dispatch alloc, resolve, retire/flush, dcache drain and status.
// master = the surrounding pipeline/dcache, slave = the store queue.
interface store_queue_if #(
  parameter int SQ_DEPTH = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  logic                alloc_valid;
  logic                alloc_ready;
  logic [SQ_DEPTH-1:0] alloc_sq_mask;
  logic                resolve_valid;
  logic [SQ_DEPTH-1:0] resolve_sq_mask;
  logic [ADDR_W-1:0]   resolve_addr;
  logic [DATA_W-1:0]   resolve_data;
  logic [3:0]          resolve_byte_mask;
  logic                retire_valid;
  logic                flush;
  logic                mem_req_valid;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_data;
  logic [3:0]          mem_req_byte_mask;
  logic                mem_req_ready;
  logic [SQ_DEPTH-1:0] unresolved_mask;
  logic                sq_empty;

  modport master (
    output alloc_valid, resolve_valid, resolve_sq_mask, resolve_addr, resolve_data,
           resolve_byte_mask, retire_valid, flush, mem_req_ready,
    input  alloc_ready, alloc_sq_mask, mem_req_valid, mem_req_addr, mem_req_data,
           mem_req_byte_mask, unresolved_mask, sq_empty
  );

  modport slave (
    input  alloc_valid, resolve_valid, resolve_sq_mask, resolve_addr, resolve_data,
           resolve_byte_mask, retire_valid, flush, mem_req_ready,
    output alloc_ready, alloc_sq_mask, mem_req_valid, mem_req_addr, mem_req_data,
           mem_req_byte_mask, unresolved_mask, sq_empty
  );
endinterface

// File: rtl/store_queue.sv
// Circular store queue: in-order alloc, out-of-order resolve, in-order retire and drain.
// Pointers carry a wrap bit above the index so full/empty need no separate counter.
module store_queue #(
  parameter int SQ_DEPTH = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  store_queue_if.slave  sq
);
  localparam int IDX_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {ST_FREE, ST_ALLOC, ST_RESOLVED, ST_COMMITTED} ent_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        bm;
  } ent_t;

  ent_state_e          st_q [SQ_DEPTH];
  ent_state_e          st_d [SQ_DEPTH];
  ent_t                ent_q [SQ_DEPTH];
  logic [PTR_W-1:0]    head_q, commit_q, tail_q;
  logic [PTR_W-1:0]    head_d, commit_d, tail_d;
  logic [SQ_DEPTH-1:0] res_hit;

  wire [IDX_W-1:0] head_idx   = head_q[IDX_W-1:0];
  wire [IDX_W-1:0] commit_idx = commit_q[IDX_W-1:0];
  wire [IDX_W-1:0] tail_idx   = tail_q[IDX_W-1:0];

  wire full = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  wire [SQ_DEPTH-1:0] rmask_m1 = sq.resolve_sq_mask - SQ_DEPTH'(1);
  wire rmask_onehot = (|sq.resolve_sq_mask) && ~|(sq.resolve_sq_mask & rmask_m1);

  wire alloc_fire = sq.alloc_valid && !full && !sq.flush;
  // Retire looks only at start-of-cycle state; a same-cycle resolve cannot enable it.
  wire retire_ok  = sq.retire_valid && (commit_q != tail_q) && (st_q[commit_idx] == ST_RESOLVED);
  wire req_valid  = (st_q[head_idx] == ST_COMMITTED);
  wire drain_fire = req_valid && sq.mem_req_ready;

  always_comb begin
    head_d   = head_q + PTR_W'(drain_fire);
    commit_d = commit_q + PTR_W'(retire_ok);
    tail_d   = sq.flush ? commit_d : tail_q + PTR_W'(alloc_fire);
    res_hit  = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      st_d[i]    = st_q[i];
      res_hit[i] = sq.resolve_valid && rmask_onehot && sq.resolve_sq_mask[i] &&
                   (st_q[i] == ST_ALLOC) && !sq.flush;
      if (drain_fire && (IDX_W'(i) == head_idx))
        st_d[i] = ST_FREE;
      else if (retire_ok && (IDX_W'(i) == commit_idx))
        st_d[i] = ST_COMMITTED;
      else if (sq.flush && (st_q[i] == ST_ALLOC || st_q[i] == ST_RESOLVED))
        st_d[i] = ST_FREE;
      else if (res_hit[i])
        st_d[i] = ST_RESOLVED;
      else if (alloc_fire && (IDX_W'(i) == tail_idx))
        st_d[i] = ST_ALLOC;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        st_q[i]  <= ST_FREE;
        ent_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        st_q[i] <= st_d[i];
        if (res_hit[i])
          ent_q[i] <= '{addr: sq.resolve_addr, data: sq.resolve_data, bm: sq.resolve_byte_mask};
      end
    end
  end

  always_comb begin
    sq.unresolved_mask = '0;
    for (int i = 0; i < SQ_DEPTH; i++)
      sq.unresolved_mask[i] = (st_q[i] == ST_ALLOC);
  end

  assign sq.alloc_ready       = !full;
  assign sq.alloc_sq_mask     = SQ_DEPTH'(1) << tail_idx;
  assign sq.sq_empty          = (head_q == tail_q);
  assign sq.mem_req_valid     = req_valid;
  // Request fields read as zero while idle so nothing stale leaks onto the dcache bus.
  assign sq.mem_req_addr      = req_valid ? (ent_q[head_idx].addr & ~ADDR_W'(3)) : '0;
  assign sq.mem_req_data      = req_valid ? ent_q[head_idx].data : '0;
  assign sq.mem_req_byte_mask = req_valid ? ent_q[head_idx].bm : '0;

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (sq.resolve_valid) assert (rmask_onehot);
      if (sq.retire_valid)  assert (retire_ok);
    end
  end
endmodule

// File: tb/tb_store_queue.sv
// Scoreboard bench for store_queue: a program-order list model predicts every output;
// retired stores are queued as expected dcache requests and popped by a drain monitor.
module tb_store_queue;
  localparam int D = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  store_queue_if #(.SQ_DEPTH(D), .ADDR_W(32), .DATA_W(32)) sq_if ();
  store_queue #(.SQ_DEPTH(D), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .sq(sq_if));

  // st: 0 = allocated, 1 = resolved, 2 = committed
  typedef struct { int st; logic [31:0] addr; logic [31:0] data; logic [3:0] bm; } ment_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] bm; } req_t;

  ment_t mq[$];
  req_t  exp_q[$];
  req_t  mon_e;
  int    head_slot = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit av, bit rv, logic [D-1:0] rm, logic [31:0] ra, logic [31:0] rd,
                            logic [3:0] rb, bit ret, bit fl, bit rdy);
    int  n;
    bit  full, drain;
    int  s, k;
    n     = mq.size();
    full  = (n == D);
    drain = (n > 0) && (mq[0].st == 2) && rdy;
    if (ret) begin
      for (int j = 0; j < n; j++) begin
        if (mq[j].st != 2) begin
          if (mq[j].st == 1) begin
            mq[j].st = 2;
            exp_q.push_back('{mq[j].addr & 32'hFFFF_FFFC, mq[j].data, mq[j].bm});
          end
          break;
        end
      end
    end
    if (rv && !fl && $onehot(rm)) begin
      s = $clog2(rm);
      k = (s - head_slot + D) % D;
      if (k < n && mq[k].st == 0) begin
        mq[k].st = 1; mq[k].addr = ra; mq[k].data = rd; mq[k].bm = rb;
      end
    end
    if (fl)
      while (mq.size() > 0 && mq[mq.size()-1].st != 2) void'(mq.pop_back());
    if (av && !full && !fl) mq.push_back('{0, 32'h0, 32'h0, 4'h0});
    if (drain) begin
      void'(mq.pop_front());
      head_slot = (head_slot + 1) % D;
    end
  endtask

  task automatic check_outputs();
    int n;
    logic [D-1:0] um;
    bit v;
    n  = mq.size();
    um = '0;
    for (int j = 0; j < n; j++)
      if (mq[j].st == 0) um[(head_slot + j) % D] = 1'b1;
    v = (n > 0) && (mq[0].st == 2);
    chk("alloc_ready", sq_if.alloc_ready, n < D);
    chk("alloc_sq_mask", sq_if.alloc_sq_mask, 64'(1) << ((head_slot + n) % D));
    chk("unresolved_mask", sq_if.unresolved_mask, um);
    chk("sq_empty", sq_if.sq_empty, n == 0);
    chk("mem_req_valid", sq_if.mem_req_valid, v);
    if (v) begin
      chk("req_addr", sq_if.mem_req_addr, mq[0].addr & 32'hFFFF_FFFC);
      chk("req_data", sq_if.mem_req_data, mq[0].data);
      chk("req_mask", sq_if.mem_req_byte_mask, mq[0].bm);
    end
  endtask

  task automatic cyc(bit av, bit rv, int rslot, logic [31:0] ra, logic [31:0] rd, logic [3:0] rb,
                     bit ret, bit fl, bit rdy);
    logic [D-1:0] rm;
    rm = rv ? (D'(1) << rslot) : '0;
    sq_if.alloc_valid = av;   sq_if.resolve_valid = rv;  sq_if.resolve_sq_mask = rm;
    sq_if.resolve_addr = ra;  sq_if.resolve_data = rd;   sq_if.resolve_byte_mask = rb;
    sq_if.retire_valid = ret; sq_if.flush = fl;          sq_if.mem_req_ready = rdy;
    @(posedge clock); #1;
    model_step(av, rv, rm, ra, rd, rb, ret, fl, rdy);
    check_outputs();
  endtask

  task automatic idle(bit rdy);            cyc(0, 0, 0, 0, 0, 0, 0, 0, rdy); endtask
  task automatic alloc1();                 cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic ret1(bit rdy);            cyc(0, 0, 0, 0, 0, 0, 1, 0, rdy); endtask
  task automatic res(int s, logic [31:0] a, logic [3:0] b, bit rdy);
    cyc(0, 1, s, a, $urandom, b, 0, 0, rdy);
  endtask

  task automatic do_reset(bit rdy);
    reset_n = 1'b0;
    sq_if.alloc_valid = 1; sq_if.resolve_valid = 0; sq_if.resolve_sq_mask = '0;
    sq_if.retire_valid = 0; sq_if.flush = 0; sq_if.mem_req_ready = rdy;
    @(posedge clock); #1;
    reset_n = 1'b1;
    mq.delete(); exp_q.delete(); head_slot = 0;
    check_outputs();
    chk("rst_addr", sq_if.mem_req_addr, 0);
    chk("rst_data", sq_if.mem_req_data, 0);
    chk("rst_mask", sq_if.mem_req_byte_mask, 0);
  endtask

  // Drain monitor: a handshake is seen at negedge, ahead of the edge that completes it.
  initial forever begin
    @(negedge clock);
    if (reset_n && sq_if.mem_req_valid && sq_if.mem_req_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL drain_unexpected: got addr %0h want no request", sq_if.mem_req_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", sq_if.mem_req_addr, mon_e.addr);
        chk("drain_data", sq_if.mem_req_data, mon_e.data);
        chk("drain_mask", sq_if.mem_req_byte_mask, mon_e.bm);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1);
  end

  initial begin
    bit av, rv, ret, fl, rdy;
    int rslot, firstnc;
    int aslots[$];

    do_reset(0);
    // fill: mask walks 0x01..0x80, 9th alloc ignored
    for (int i = 0; i < 9; i++) alloc1();
    res(0, 32'h1003, 4'h8, 0);
    ret1(0);
    idle(1);
    idle(0);
    res(1, 32'h2006, 4'hC, 0);
    ret1(0);
    for (int i = 0; i < 5; i++) idle(0);
    idle(1);
    idle(1);

    // out-of-order resolve, in-order drain
    do_reset(0);
    for (int i = 0; i < 3; i++) alloc1();
    res(2, 32'h3008, 4'hF, 0);
    res(0, 32'h3000, 4'h1, 0);
    res(1, 32'h3004, 4'h2, 0);
    for (int i = 0; i < 3; i++) ret1(1);
    for (int i = 0; i < 3; i++) idle(1);

    // commit 2, flush with same-cycle alloc
    do_reset(0);
    for (int i = 0; i < 3; i++) alloc1();
    for (int i = 0; i < 3; i++) res(i, 32'h4000 + 32'(i * 4), 4'h3, 0);
    ret1(0);
    ret1(0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) idle(1);

    // fill, drain 3, refill 3 (wrap), then reset mid-drain
    do_reset(0);
    for (int i = 0; i < D; i++) alloc1();
    for (int i = 0; i < D; i++) res(i, 32'h5000 + 32'(i * 16 + i % 4), 4'(i + 1), 0);
    for (int i = 0; i < 3; i++) ret1(0);
    for (int i = 0; i < 3; i++) idle(1);
    for (int i = 0; i < 4; i++) alloc1();
    ret1(1);
    do_reset(1);
    idle(1);

    // randomized traffic with only legal resolve/retire
    for (int c = 0; c < 3000; c++) begin
      av  = ($urandom % 3) != 0;
      rdy = ($urandom % 4) != 0;
      fl  = ($urandom % 40) == 0;
      rv = 0; rslot = 0;
      aslots.delete();
      for (int j = 0; j < mq.size(); j++)
        if (mq[j].st == 0) aslots.push_back((head_slot + j) % D);
      if (aslots.size() > 0 && ($urandom % 4) != 0) begin
        rv = 1; rslot = aslots[$urandom % aslots.size()];
      end else if (($urandom % 8) == 0) begin
        rv = 1; rslot = $urandom % D;
      end
      firstnc = -1;
      for (int j = 0; j < mq.size(); j++)
        if (mq[j].st != 2) begin firstnc = j; break; end
      ret = (firstnc >= 0) && (mq[firstnc].st == 1) && (($urandom % 2) != 0);
      cyc(av, rv, rslot, $urandom, $urandom, 4'($urandom), ret, fl, rdy);
      if (c % 1000 == 999) do_reset(1'($urandom % 2));
    end

    for (int i = 0; i < 2 * D; i++) idle(1);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
